// File: rtl/vtx_trace_pkg.sv
// Shared types and constants for the vertex trace controller and its memory log.
package vtx_trace_pkg;

    localparam int VTX_NUM_MEM_TXN     = 4;
    localparam int VTX_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_REPORT = 2'd2
    } vtx_state_t;

    typedef struct packed {
        logic        cen;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  ben;
        logic        error;
    } vtx_mem_slot_t;

endpackage

// File: rtl/vtx_trace_memlog.sv
// Per-instruction memory transaction log: request phase fills a slot, the
// following cycle's data phase completes it and bumps the visible count.
module vtx_trace_memlog
    import vtx_trace_pkg::*;
#(
    parameter int NUM_MEM_TXN = VTX_NUM_MEM_TXN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     accept,
    input  logic                     req_wen,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    input  logic [3:0]               req_ben,
    input  logic [31:0]              rsp_rdata,
    input  logic                     rsp_error,
    output logic [NUM_MEM_TXN-1:0]   mem_cen,
    output logic [NUM_MEM_TXN-1:0]   mem_wen,
    output logic [NUM_MEM_TXN-1:0]   mem_error,
    output logic [32*NUM_MEM_TXN-1:0] mem_addr,
    output logic [32*NUM_MEM_TXN-1:0] mem_wdata,
    output logic [32*NUM_MEM_TXN-1:0] mem_rdata,
    output logic [4*NUM_MEM_TXN-1:0] mem_ben,
    output logic [2:0]               mem_count,
    output logic                     mem_ovf
);

    localparam int IW = (NUM_MEM_TXN > 1) ? $clog2(NUM_MEM_TXN) : 1;
    localparam logic [2:0] SLOTS = 3'(NUM_MEM_TXN);

    vtx_mem_slot_t   slot_reg [NUM_MEM_TXN];
    logic [2:0]      ptr_reg;
    logic [2:0]      count_reg;
    logic            ovf_reg;
    logic            pend_reg;
    logic [IW-1:0]   pend_idx_reg;

    // ptr_reg allocates slots at request time so back-to-back accepts never
    // collide; count_reg only advances once the data phase has landed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MEM_TXN; i++) slot_reg[i] <= '0;
            ptr_reg      <= '0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            pend_reg     <= 1'b0;
            pend_idx_reg <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_MEM_TXN; i++) slot_reg[i] <= '0;
            ptr_reg      <= '0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            pend_reg     <= 1'b0;
            pend_idx_reg <= '0;
        end else begin
            pend_reg <= 1'b0;
            if (accept) begin
                if (ptr_reg < SLOTS) begin
                    slot_reg[ptr_reg[IW-1:0]].cen   <= 1'b1;
                    slot_reg[ptr_reg[IW-1:0]].wen   <= req_wen;
                    slot_reg[ptr_reg[IW-1:0]].addr  <= req_addr;
                    slot_reg[ptr_reg[IW-1:0]].wdata <= req_wdata;
                    slot_reg[ptr_reg[IW-1:0]].ben   <= req_ben;
                    pend_reg     <= 1'b1;
                    pend_idx_reg <= ptr_reg[IW-1:0];
                    ptr_reg      <= ptr_reg + 3'd1;
                end else begin
                    ovf_reg <= 1'b1;
                end
            end
            if (pend_reg) begin
                slot_reg[pend_idx_reg].rdata <= rsp_rdata;
                slot_reg[pend_idx_reg].error <= rsp_error;
                count_reg <= count_reg + 3'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_MEM_TXN; gi++) begin : g_slot
            assign mem_cen[gi]            = slot_reg[gi].cen;
            assign mem_wen[gi]            = slot_reg[gi].wen;
            assign mem_error[gi]          = slot_reg[gi].error;
            assign mem_addr[32*gi +: 32]  = slot_reg[gi].addr;
            assign mem_wdata[32*gi +: 32] = slot_reg[gi].wdata;
            assign mem_rdata[32*gi +: 32] = slot_reg[gi].rdata;
            assign mem_ben[4*gi +: 4]     = slot_reg[gi].ben;
        end
    endgenerate

    assign mem_count = count_reg;
    assign mem_ovf   = ovf_reg;

endmodule

// File: rtl/vtx_trace_ctrl.sv
// Instruction trace controller: IDLE -> BUSY -> REPORT record of one coprocessor
// instruction. Define VTX_TRACE_TIMEOUT_EN to build the BUSY watchdog.
module vtx_trace_ctrl
    import vtx_trace_pkg::*;
#(
    parameter int NUM_MEM_TXN    = VTX_NUM_MEM_TXN,
    parameter int TIMEOUT_CYCLES = VTX_TIMEOUT_DEFAULT
) (
    input  logic                      g_clk,
    input  logic                      g_reset,
    input  logic                      cpu_insn_req,
    input  logic                      cop_insn_ack,
    input  logic                      cop_insn_rsp,
    input  logic                      cpu_insn_ack,
    input  logic [31:0]               cpu_insn_enc,
    input  logic [31:0]               cpu_insn_rs1,
    input  logic [31:0]               cpu_insn_rs2,
    input  logic [2:0]                cop_result,
    input  logic                      cop_wen,
    input  logic [4:0]                cop_waddr,
    input  logic [31:0]               cop_wdata,
    input  logic                      cop_mem_cen,
    input  logic                      cop_mem_wen,
    input  logic                      cop_mem_stall,
    input  logic [31:0]               cop_mem_addr,
    input  logic [31:0]               cop_mem_wdata,
    input  logic [3:0]                cop_mem_ben,
    input  logic [31:0]               cop_mem_rdata,
    input  logic                      cop_mem_error,
    output logic                      vtx_snap_pre,
    output logic                      vtx_snap_post,
    output logic                      vtx_valid,
    output logic [31:0]               vtx_instr_enc,
    output logic [31:0]               vtx_instr_rs1,
    output logic [31:0]               vtx_instr_rs2,
    output logic [2:0]                vtx_instr_result,
    output logic                      vtx_instr_wen,
    output logic [4:0]                vtx_instr_waddr,
    output logic [31:0]               vtx_instr_wdata,
    output logic [NUM_MEM_TXN-1:0]    vtx_mem_cen,
    output logic [NUM_MEM_TXN-1:0]    vtx_mem_wen,
    output logic [NUM_MEM_TXN-1:0]    vtx_mem_error,
    output logic [32*NUM_MEM_TXN-1:0] vtx_mem_addr,
    output logic [32*NUM_MEM_TXN-1:0] vtx_mem_wdata,
    output logic [32*NUM_MEM_TXN-1:0] vtx_mem_rdata,
    output logic [4*NUM_MEM_TXN-1:0]  vtx_mem_ben,
    output logic [2:0]                vtx_mem_count,
    output logic                      vtx_mem_ovf,
    output logic                      vtx_timeout
);

    vtx_state_t state_reg;
    logic       issue;
    logic       response;
    logic       accept;

    assign issue    = cpu_insn_req & cop_insn_ack & (state_reg != ST_BUSY);
    assign response = cop_insn_rsp & cpu_insn_ack & (state_reg == ST_BUSY);
    assign accept   = cop_mem_cen & ~cop_mem_stall & (state_reg == ST_BUSY);

    // Snapshot strobes are combinational so the CPR datapath captures in the
    // handshake cycle itself; reset masks them immediately.
    assign vtx_snap_pre  = issue & ~g_reset;
    assign vtx_snap_post = response & ~g_reset;

`ifdef VTX_TRACE_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt_reg;
    logic        timeout_reg;
    assign vtx_timeout = timeout_reg;
`else
    assign vtx_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_reg        <= ST_IDLE;
            vtx_valid        <= 1'b0;
            vtx_instr_enc    <= '0;
            vtx_instr_rs1    <= '0;
            vtx_instr_rs2    <= '0;
            vtx_instr_result <= '0;
            vtx_instr_wen    <= 1'b0;
            vtx_instr_waddr  <= '0;
            vtx_instr_wdata  <= '0;
`ifdef VTX_TRACE_TIMEOUT_EN
            tmo_cnt_reg      <= '0;
            timeout_reg      <= 1'b0;
`endif
        end else begin
            vtx_valid <= 1'b0;
`ifdef VTX_TRACE_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                ST_BUSY: begin
                    if (response) begin
                        vtx_instr_result <= cop_result;
                        vtx_instr_wen    <= cop_wen;
                        vtx_instr_waddr  <= cop_waddr;
                        vtx_instr_wdata  <= cop_wdata;
                        vtx_valid        <= 1'b1;
                        state_reg        <= ST_REPORT;
                    end
`ifdef VTX_TRACE_TIMEOUT_EN
                    else if (tmo_cnt_reg == TMO_LAST) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
                    end
`endif
                end
                default: begin
                    // IDLE and REPORT both accept a new issue; REPORT lasts one cycle.
                    if (issue) begin
                        vtx_instr_enc    <= cpu_insn_enc;
                        vtx_instr_rs1    <= cpu_insn_rs1;
                        vtx_instr_rs2    <= cpu_insn_rs2;
                        vtx_instr_result <= '0;
                        vtx_instr_wen    <= 1'b0;
                        vtx_instr_waddr  <= '0;
                        vtx_instr_wdata  <= '0;
`ifdef VTX_TRACE_TIMEOUT_EN
                        tmo_cnt_reg      <= '0;
`endif
                        state_reg        <= ST_BUSY;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    vtx_trace_memlog #(
        .NUM_MEM_TXN(NUM_MEM_TXN)
    ) u_memlog (
        .clk       (g_clk),
        .rst       (g_reset),
        .clear     (issue),
        .accept    (accept),
        .req_wen   (cop_mem_wen),
        .req_addr  (cop_mem_addr),
        .req_wdata (cop_mem_wdata),
        .req_ben   (cop_mem_ben),
        .rsp_rdata (cop_mem_rdata),
        .rsp_error (cop_mem_error),
        .mem_cen   (vtx_mem_cen),
        .mem_wen   (vtx_mem_wen),
        .mem_error (vtx_mem_error),
        .mem_addr  (vtx_mem_addr),
        .mem_wdata (vtx_mem_wdata),
        .mem_rdata (vtx_mem_rdata),
        .mem_ben   (vtx_mem_ben),
        .mem_count (vtx_mem_count),
        .mem_ovf   (vtx_mem_ovf)
    );

endmodule

// File: tb/tb_vtx_trace_ctrl.sv
// Scoreboard bench for vtx_trace_ctrl: expected records are queued at the
// response handshake and compared when vtx_valid appears.
module tb_vtx_trace_ctrl;

    localparam int N = 4;

    logic            g_clk = 1'b0;
    logic            g_reset;
    logic            cpu_insn_req, cop_insn_ack, cop_insn_rsp, cpu_insn_ack;
    logic [31:0]     cpu_insn_enc, cpu_insn_rs1, cpu_insn_rs2;
    logic [2:0]      cop_result;
    logic            cop_wen;
    logic [4:0]      cop_waddr;
    logic [31:0]     cop_wdata;
    logic            cop_mem_cen, cop_mem_wen, cop_mem_stall, cop_mem_error;
    logic [31:0]     cop_mem_addr, cop_mem_wdata, cop_mem_rdata;
    logic [3:0]      cop_mem_ben;
    logic            vtx_snap_pre, vtx_snap_post, vtx_valid;
    logic [31:0]     vtx_instr_enc, vtx_instr_rs1, vtx_instr_rs2, vtx_instr_wdata;
    logic [2:0]      vtx_instr_result;
    logic            vtx_instr_wen;
    logic [4:0]      vtx_instr_waddr;
    logic [N-1:0]    vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
    logic [32*N-1:0] vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata;
    logic [4*N-1:0]  vtx_mem_ben;
    logic [2:0]      vtx_mem_count;
    logic            vtx_mem_ovf, vtx_timeout;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] enc, rs1, rs2, wdata;
        logic [2:0]  result;
        logic        wen;
        logic [4:0]  waddr;
        logic [2:0]  count;
        logic        ovf;
    } exp_t;
    exp_t exp_q[$];

    vtx_trace_ctrl #(.NUM_MEM_TXN(N), .TIMEOUT_CYCLES(8)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_insn_rs1(cpu_insn_rs1), .cpu_insn_rs2(cpu_insn_rs2),
        .cop_result(cop_result), .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
        .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_stall(cop_mem_stall),
        .cop_mem_addr(cop_mem_addr), .cop_mem_wdata(cop_mem_wdata), .cop_mem_ben(cop_mem_ben),
        .cop_mem_rdata(cop_mem_rdata), .cop_mem_error(cop_mem_error),
        .vtx_snap_pre(vtx_snap_pre), .vtx_snap_post(vtx_snap_post), .vtx_valid(vtx_valid),
        .vtx_instr_enc(vtx_instr_enc), .vtx_instr_rs1(vtx_instr_rs1), .vtx_instr_rs2(vtx_instr_rs2),
        .vtx_instr_result(vtx_instr_result), .vtx_instr_wen(vtx_instr_wen),
        .vtx_instr_waddr(vtx_instr_waddr), .vtx_instr_wdata(vtx_instr_wdata),
        .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen), .vtx_mem_error(vtx_mem_error),
        .vtx_mem_addr(vtx_mem_addr), .vtx_mem_wdata(vtx_mem_wdata), .vtx_mem_rdata(vtx_mem_rdata),
        .vtx_mem_ben(vtx_mem_ben), .vtx_mem_count(vtx_mem_count), .vtx_mem_ovf(vtx_mem_ovf),
        .vtx_timeout(vtx_timeout)
    );

    always #5 g_clk = ~g_clk;

    // Scoreboard consumer: every vtx_valid must match the oldest queued record.
    always @(negedge g_clk) begin
        if (g_reset === 1'b0 && vtx_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got vtx_valid=1 enc=%h, required no record", vtx_instr_enc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (vtx_instr_enc !== e.enc || vtx_instr_rs1 !== e.rs1 || vtx_instr_rs2 !== e.rs2 ||
                    vtx_instr_result !== e.result || vtx_instr_wen !== e.wen ||
                    vtx_instr_waddr !== e.waddr || vtx_instr_wdata !== e.wdata ||
                    vtx_mem_count !== e.count || vtx_mem_ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL record: got enc=%h rs1=%h rs2=%h res=%0d wen=%b waddr=%0d wdata=%h cnt=%0d ovf=%b, required enc=%h rs1=%h rs2=%h res=%0d wen=%b waddr=%0d wdata=%h cnt=%0d ovf=%b",
                        vtx_instr_enc, vtx_instr_rs1, vtx_instr_rs2, vtx_instr_result, vtx_instr_wen,
                        vtx_instr_waddr, vtx_instr_wdata, vtx_mem_count, vtx_mem_ovf,
                        e.enc, e.rs1, e.rs2, e.result, e.wen, e.waddr, e.wdata, e.count, e.ovf);
                end else begin
                    $display("txn enc=%h rs1=%h wdata=%h cnt=%0d ovf=%b ok", vtx_instr_enc,
                        vtx_instr_rs1, vtx_instr_wdata, vtx_mem_count, vtx_mem_ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_insn_req = 0; cop_insn_ack = 0; cop_insn_rsp = 0; cpu_insn_ack = 0;
        cpu_insn_enc = 0; cpu_insn_rs1 = 0; cpu_insn_rs2 = 0;
        cop_result = 0; cop_wen = 0; cop_waddr = 0; cop_wdata = 0;
        cop_mem_cen = 0; cop_mem_wen = 0; cop_mem_stall = 0; cop_mem_error = 0;
        cop_mem_addr = 0; cop_mem_wdata = 0; cop_mem_rdata = 0; cop_mem_ben = 0;
    endtask

    task automatic drive_issue(input logic [31:0] enc, input logic [31:0] rs1, input logic [31:0] rs2);
        cpu_insn_req = 1; cop_insn_ack = 1;
        cpu_insn_enc = enc; cpu_insn_rs1 = rs1; cpu_insn_rs2 = rs2;
    endtask

    // Drives a response and queues the record it should produce.
    task automatic drive_rsp(input logic [31:0] enc, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [2:0] res, input logic wen, input logic [4:0] waddr,
                             input logic [31:0] wdata, input logic [2:0] cnt, input logic ovf);
        exp_t e;
        cop_insn_rsp = 1; cpu_insn_ack = 1;
        cop_result = res; cop_wen = wen; cop_waddr = waddr; cop_wdata = wdata;
        e.enc = enc; e.rs1 = rs1; e.rs2 = rs2; e.result = res; e.wen = wen;
        e.waddr = waddr; e.wdata = wdata; e.count = cnt; e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        g_reset = 1;
        clear_inputs();
        #3;
        checks++;
        if ({vtx_valid, vtx_snap_pre, vtx_snap_post, vtx_instr_enc, vtx_mem_count, vtx_mem_ovf,
             vtx_mem_cen, vtx_mem_addr, vtx_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b enc=%h cnt=%0d cen=%b, required all zero",
                vtx_valid, vtx_instr_enc, vtx_mem_count, vtx_mem_cen);
        end
        tick(); tick();
        g_reset = 0;
        tick();
    endtask

    task automatic test_basic();
        drive_issue(32'h0000_102B, 32'h11, 32'h0);                       // cycle 0
        @(negedge g_clk);
        checks++;
        if (vtx_snap_pre !== 1'b1 || vtx_snap_post !== 1'b0) begin
            failures++;
            $display("FAIL basic_snap_pre: got pre=%b post=%b, required pre=1 post=0", vtx_snap_pre, vtx_snap_post);
        end
        tick(); clear_inputs();                                           // cycle 1
        @(negedge g_clk);
        checks++;
        if (vtx_snap_pre !== 1'b0 || vtx_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy: got pre=%b valid=%b, required 0 0", vtx_snap_pre, vtx_valid);
        end
        tick(); tick();                                                   // cycle 3
        drive_rsp(32'h0000_102B, 32'h11, 32'h0, 3'd1, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 1'b0);
        @(negedge g_clk);
        checks++;
        if (vtx_snap_post !== 1'b1 || vtx_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_snap_post: got post=%b valid=%b, required post=1 valid=0", vtx_snap_post, vtx_valid);
        end
        tick(); clear_inputs();                                           // cycle 4
        @(negedge g_clk);
        checks++;
        if (vtx_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_valid_c4: got %b, required 1", vtx_valid);
        end
        tick();
        @(negedge g_clk);
        checks++;
        if (vtx_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_c5: got %b, required 0", vtx_valid);
        end
        tick();
    endtask

    task automatic test_mem_two();
        drive_issue(32'h0000_2003, 32'h22, 32'h33);                       // cycle 0
        tick(); clear_inputs();                                           // cycle 1: stalled
        cop_mem_cen = 1; cop_mem_stall = 1; cop_mem_addr = 32'h100;
        tick();                                                           // cycle 2: read accept
        cop_mem_stall = 0;
        tick();                                                           // cycle 3: write accept
        cop_mem_wen = 1; cop_mem_addr = 32'h104; cop_mem_wdata = 32'h1234_5678; cop_mem_ben = 4'hF;
        cop_mem_rdata = 32'hA5A5A5A5;
        tick();                                                           // cycle 4: data + response
        cop_mem_cen = 0; cop_mem_wen = 0; cop_mem_rdata = 32'h0BAD_0000;
        drive_rsp(32'h0000_2003, 32'h22, 32'h33, 3'd0, 1'b0, 5'd0, 32'h0, 3'd2, 1'b0);
        tick(); clear_inputs();                                           // cycle 5: REPORT
        @(negedge g_clk);
        checks++;
        if (vtx_mem_rdata[31:0] !== 32'hA5A5A5A5 || vtx_mem_addr[31:0] !== 32'h100) begin
            failures++;
            $display("FAIL mem_slot0: got addr=%h rdata=%h, required 00000100 a5a5a5a5",
                vtx_mem_addr[31:0], vtx_mem_rdata[31:0]);
        end
        checks++;
        if (vtx_mem_wen !== 4'b0010 || vtx_mem_cen !== 4'b0011 || vtx_mem_ben[7:4] !== 4'hF ||
            vtx_mem_addr[63:32] !== 32'h104 || vtx_mem_wdata[63:32] !== 32'h1234_5678 ||
            vtx_mem_rdata[63:32] !== 32'h0BAD_0000) begin
            failures++;
            $display("FAIL mem_slot1: got wen=%b cen=%b ben1=%h addr1=%h wdata1=%h rdata1=%h, required 0010 0011 f 00000104 12345678 0bad0000",
                vtx_mem_wen, vtx_mem_cen, vtx_mem_ben[7:4], vtx_mem_addr[63:32],
                vtx_mem_wdata[63:32], vtx_mem_rdata[63:32]);
        end
        tick();
    endtask

    task automatic test_overflow();
        drive_issue(32'h0000_3003, 32'h44, 32'h55);                       // cycle 0
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) clear_inputs();
            cop_mem_cen  = (k <= 5);
            cop_mem_addr = 32'h200 + 32'(4 * (k - 1));
            cop_mem_rdata = (k >= 2) ? 32'hC000_0000 + 32'(k - 2) : 32'h0;
            if (k == 6) drive_rsp(32'h0000_3003, 32'h44, 32'h55, 3'd2, 1'b1, 5'd9, 32'h77, 3'd4, 1'b1);
        end
        tick(); clear_inputs();                                           // cycle 7: REPORT
        @(negedge g_clk);
        checks++;
        if (vtx_mem_cen !== 4'hF) begin
            failures++;
            $display("FAIL ovf_cen: got %b, required 1111", vtx_mem_cen);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (vtx_mem_addr[32*i +: 32] !== 32'h200 + 32'(4 * i) ||
                vtx_mem_rdata[32*i +: 32] !== 32'hC000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL ovf_slot%0d: got addr=%h rdata=%h, required %h %h", i,
                    vtx_mem_addr[32*i +: 32], vtx_mem_rdata[32*i +: 32],
                    32'h200 + 32'(4 * i), 32'hC000_0000 + 32'(i));
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        cop_insn_rsp = 1; cpu_insn_ack = 1;                               // response in IDLE
        @(negedge g_clk);
        checks++;
        if (vtx_snap_post !== 1'b0) begin
            failures++;
            $display("FAIL idle_rsp_snap: got post=%b, required 0", vtx_snap_post);
        end
        tick(); clear_inputs();
        @(negedge g_clk);
        checks++;
        if (vtx_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_rsp_valid: got %b, required 0", vtx_valid);
        end
        tick();
        drive_issue(32'hAAAA_0001, 32'h1, 32'h2);                         // cycle 0: A
        tick();
        drive_issue(32'hBBBB_0002, 32'h3, 32'h4);                         // cycle 1: ignored B
        @(negedge g_clk);
        checks++;
        if (vtx_snap_pre !== 1'b0) begin
            failures++;
            $display("FAIL busy_issue_snap: got pre=%b, required 0", vtx_snap_pre);
        end
        tick(); clear_inputs();                                           // cycle 2: respond A
        drive_rsp(32'hAAAA_0001, 32'h1, 32'h2, 3'd3, 1'b1, 5'd7, 32'h1111_2222, 3'd0, 1'b0);
        tick(); clear_inputs();                                           // cycle 3: REPORT + issue C
        drive_issue(32'hCCCC_0003, 32'h5, 32'h6);
        @(negedge g_clk);
        checks++;
        if (vtx_snap_pre !== 1'b1 || vtx_valid !== 1'b1 || vtx_instr_enc !== 32'hAAAA_0001) begin
            failures++;
            $display("FAIL report_issue: got pre=%b valid=%b enc=%h, required 1 1 aaaa0001",
                vtx_snap_pre, vtx_valid, vtx_instr_enc);
        end
        tick(); clear_inputs();                                           // cycle 4: BUSY for C
        @(negedge g_clk);
        checks++;
        if (vtx_valid !== 1'b0 || vtx_instr_enc !== 32'hCCCC_0003) begin
            failures++;
            $display("FAIL report_issue_next: got valid=%b enc=%h, required 0 cccc0003", vtx_valid, vtx_instr_enc);
        end
        tick();
        drive_rsp(32'hCCCC_0003, 32'h5, 32'h6, 3'd0, 1'b0, 5'd1, 32'h3333_4444, 3'd0, 1'b0);
        tick(); clear_inputs();
        tick();
    endtask

    task automatic test_reset_busy();
        int bad;
        drive_issue(32'hCAFE_0000, 32'h9, 32'h8);                         // cycle 0
        tick(); clear_inputs();                                           // cycle 1: accept
        cop_mem_cen = 1; cop_mem_addr = 32'h300;
        tick(); clear_inputs();                                           // cycle 2 of BUSY
        drive_issue(32'hDEAD_0000, 32'h1, 32'h1);
        g_reset = 1;
        #1;
        checks++;
        if ({vtx_valid, vtx_snap_pre, vtx_snap_post, vtx_instr_enc, vtx_instr_rs1,
             vtx_mem_count, vtx_mem_cen, vtx_mem_addr} !== '0) begin
            failures++;
            $display("FAIL reset_busy_outputs: got pre=%b enc=%h cen=%b addr0=%h, required all zero",
                vtx_snap_pre, vtx_instr_enc, vtx_mem_cen, vtx_mem_addr[31:0]);
        end
        clear_inputs();
        tick(); tick();
        g_reset = 0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 2) begin cop_insn_rsp = 1; cpu_insn_ack = 1; end
            else clear_inputs();
            @(negedge g_clk);
            if (vtx_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_busy_no_valid: got %0d valid cycles, required 0", bad);
        end
        clear_inputs();
        tick();
    endtask

`ifdef VTX_TRACE_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        drive_issue(32'h7777_0000, 32'h1, 32'h2);                         // cycle 0
        early = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(); clear_inputs();
            @(negedge g_clk);
            if (vtx_timeout !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL timeout_early: got %0d pulses in BUSY, required 0", early);
        end
        tick();                                                           // cycle 9
        @(negedge g_clk);
        checks++;
        if (vtx_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_pulse: got %b, required 1", vtx_timeout);
        end
        tick();                                                           // cycle 10: now IDLE
        cop_insn_rsp = 1; cpu_insn_ack = 1;
        @(negedge g_clk);
        checks++;
        if (vtx_timeout !== 1'b0 || vtx_snap_post !== 1'b0) begin
            failures++;
            $display("FAIL timeout_after: got timeout=%b post=%b, required 0 0", vtx_timeout, vtx_snap_post);
        end
        tick(); clear_inputs();
        @(negedge g_clk);
        checks++;
        if (vtx_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_no_valid: got %b, required 0", vtx_valid);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        drive_issue(32'h7777_0000, 32'h1, 32'h2);
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(); clear_inputs();
            @(negedge g_clk);
            if (vtx_timeout !== 1'b0 || vtx_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL no_timeout_wait: got %0d bad cycles, required 0", bad);
        end
        tick();
        drive_rsp(32'h7777_0000, 32'h1, 32'h2, 3'd5, 1'b1, 5'd31, 32'hFEED_F00D, 3'd0, 1'b0);
        tick(); clear_inputs();
        @(negedge g_clk);
        checks++;
        if (vtx_valid !== 1'b1) begin
            failures++;
            $display("FAIL no_timeout_valid: got %b, required 1", vtx_valid);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_mem_two();
        test_overflow();
        test_back_to_back();
        test_reset_busy();
`ifdef VTX_TRACE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d records never reported, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
